// File: rtl/ls_pkg.sv
// Shared definitions for the Longstaff-Schwartz datapath: width constants,
// the evaluator FSM state type and the price clamp used by every stage that
// turns a wide signed accumulator back into a 12-bit price.
package ls_pkg;

  localparam int PRICE_W = 12;
  localparam int COEF_W  = 24;
  localparam int ACC_W   = 50;
  localparam int EXCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ls_state_t;

  // Saturate a signed accumulator into the unsigned price range [0, 2^PRICE_W-1].
  function automatic logic [PRICE_W-1:0] clamp_price(input logic signed [ACC_W-1:0] v);
    logic [PRICE_W-1:0] r;
    if (v[ACC_W-1]) begin
      r = '0;
    end else if (|v[ACC_W-2:PRICE_W]) begin
      r = '1;
    end else begin
      r = v[PRICE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ls_poly2_eval.sv
// Three-stage evaluator of E = c0 + c1*x + c2*x^2 (coefficients Q.FRAC) with
// the exercise decision folded into the last stage.
//   S1: x, x^2, profit, future_cf
//   S2: c1*x, c2*x^2 (full precision)
//   S3: sum, floor shift, clamp, compare, registered outputs
// No backpressure: a valid sample moves one stage per clock.
module ls_poly2_eval
  import ls_pkg::*;
#(
  parameter int FRAC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [PRICE_W-1:0] x,
  input  logic [PRICE_W-1:0] profit,
  input  logic [PRICE_W-1:0] future_cf,
  input  logic [COEF_W-1:0]  c0,
  input  logic [COEF_W-1:0]  c1,
  input  logic [COEF_W-1:0]  c2,
  output logic               front_busy,
  output logic               out_valid,
  output logic [PRICE_W-1:0] expected_profit,
  output logic               exercise,
  output logic [PRICE_W-1:0] cf_out
);

  localparam int X2_W = 2 * PRICE_W;
  localparam int P1_W = COEF_W + PRICE_W + 1;
  localparam int P2_W = COEF_W + X2_W + 1;

  // S1 registers
  logic               s1_valid;
  logic [PRICE_W-1:0] s1_x;
  logic [X2_W-1:0]    s1_x2;
  logic [PRICE_W-1:0] s1_profit;
  logic [PRICE_W-1:0] s1_cf;

  // S2 registers
  logic                   s2_valid;
  logic signed [P1_W-1:0] s2_p1;
  logic signed [P2_W-1:0] s2_p2;
  logic [PRICE_W-1:0]     s2_profit;
  logic [PRICE_W-1:0]     s2_cf;

  // Combinational operands, widened explicitly so no product loses bits
  logic [X2_W-1:0]         x_wide;
  logic [X2_W-1:0]         x2_c;
  logic signed [P1_W-1:0]  c1_ext;
  logic signed [P1_W-1:0]  x_ext;
  logic signed [P1_W-1:0]  p1_c;
  logic signed [P2_W-1:0]  c2_ext;
  logic signed [P2_W-1:0]  x2_ext;
  logic signed [P2_W-1:0]  p2_c;
  logic signed [ACC_W-1:0] c0_acc;
  logic signed [ACC_W-1:0] p1_acc;
  logic signed [ACC_W-1:0] p2_acc;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] e_c;
  logic [PRICE_W-1:0]      ep_c;
  logic                    ex_c;
  logic [PRICE_W-1:0]      cf_c;

  assign x_wide = {{(X2_W-PRICE_W){1'b0}}, x};
  assign x2_c   = x_wide * x_wide;

  // x and x^2 are unsigned; a zero guard bit makes them non-negative signed operands.
  assign c1_ext = {{(P1_W-COEF_W){c1[COEF_W-1]}}, c1};
  assign x_ext  = {{(P1_W-PRICE_W){1'b0}}, s1_x};
  assign p1_c   = c1_ext * x_ext;
  assign c2_ext = {{(P2_W-COEF_W){c2[COEF_W-1]}}, c2};
  assign x2_ext = {{(P2_W-X2_W){1'b0}}, s1_x2};
  assign p2_c   = c2_ext * x2_ext;

  assign c0_acc = {{(ACC_W-COEF_W){c0[COEF_W-1]}}, c0};
  assign p1_acc = {{(ACC_W-P1_W){s2_p1[P1_W-1]}}, s2_p1};
  assign p2_acc = {{(ACC_W-P2_W){s2_p2[P2_W-1]}}, s2_p2};
  assign sum_c  = c0_acc + p1_acc + p2_acc;
  // Arithmetic shift floors toward minus infinity, matching the Q-format intent.
  assign e_c    = sum_c >>> FRAC;
  assign ep_c   = clamp_price(e_c);
  // Strict compare: a tie holds; a zero profit (out of the money) never exercises.
  assign ex_c   = (s2_profit != '0) && (s2_profit > ep_c);
  assign cf_c   = ex_c ? s2_profit : s2_cf;

  assign front_busy = s1_valid | s2_valid;

  // S1: capture the accepted sample together with its square
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_x2     <= '0;
      s1_profit <= '0;
      s1_cf     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x      <= x;
        s1_x2     <= x2_c;
        s1_profit <= profit;
        s1_cf     <= future_cf;
      end
    end
  end

  // S2: register both products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_p1     <= '0;
      s2_p2     <= '0;
      s2_profit <= '0;
      s2_cf     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p1     <= p1_c;
        s2_p2     <= p2_c;
        s2_profit <= s1_profit;
        s2_cf     <= s1_cf;
      end
    end
  end

  // S3: sum, clamp, exercise decision and result strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      expected_profit <= '0;
      exercise        <= 1'b0;
      cf_out          <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        expected_profit <= ep_c;
        exercise        <= ex_c;
        cf_out          <= cf_c;
      end
    end
  end

endmodule

// File: rtl/ls_exercise_eval.sv
// Early-exercise evaluator: latches a coefficient set, replays the N paths of
// one time step through ls_poly2_eval and pulses done after the last result.
// Optional feature macro: LS_EXCNT_EN adds the per-step exercise_count output.
// Handshake: a sample transfers on a clock edge where in_valid && in_ready;
// in_ready is high only in RUN and depends on state alone. Results carry no
// backpressure: out_valid is a one-cycle strobe per accepted sample.
module ls_exercise_eval
  import ls_pkg::*;
#(
  parameter int N    = 128,
  parameter int FRAC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coef_load,
  input  logic [COEF_W-1:0]  c0,
  input  logic [COEF_W-1:0]  c1,
  input  logic [COEF_W-1:0]  c2,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PRICE_W-1:0] x,
  input  logic [PRICE_W-1:0] profit,
  input  logic [PRICE_W-1:0] future_cf,
  output logic               out_valid,
  output logic [PRICE_W-1:0] expected_profit,
  output logic               exercise,
  output logic [PRICE_W-1:0] cf_out,
  output logic               done,
`ifdef LS_EXCNT_EN
  output logic [EXCNT_W-1:0] exercise_count,
`endif
  output ls_state_t          fsm_state
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  ls_state_t         state;
  ls_state_t         state_nxt;
  logic [CNT_W-1:0]  sample_cnt;
  logic [COEF_W-1:0] c0_q;
  logic [COEF_W-1:0] c1_q;
  logic [COEF_W-1:0] c2_q;
  logic              coef_we;
  logic              drain_end;
  logic              accept;
  logic              last_accept;
  logic              front_busy;
  logic              pipe_last;

  assign in_ready    = (state == ST_RUN);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (sample_cnt == LAST_IDX);
  // Only the final result is still in S3 and nothing follows it.
  assign pipe_last   = out_valid && !front_busy;
  assign fsm_state   = state;

  // Next-state logic: load -> run N samples -> drain -> idle
  always_comb begin
    state_nxt = state;
    coef_we   = 1'b0;
    drain_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coef_load) begin
          coef_we   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_accept) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_last) begin
          drain_end = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= drain_end;
    end
  end

  // Sample counter: restarts with each coefficient load and wraps after the last path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (coef_we) begin
      sample_cnt <= '0;
    end else if (accept) begin
      sample_cnt <= last_accept ? '0 : sample_cnt + 1'b1;
    end
  end

  // Coefficient latch, written only from IDLE so a step sees one stable set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_q <= '0;
      c1_q <= '0;
      c2_q <= '0;
    end else if (coef_we) begin
      c0_q <= c0;
      c1_q <= c1;
      c2_q <= c2;
    end
  end

  ls_poly2_eval #(
    .FRAC (FRAC)
  ) u_poly (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (accept),
    .x               (x),
    .profit          (profit),
    .future_cf       (future_cf),
    .c0              (c0_q),
    .c1              (c1_q),
    .c2              (c2_q),
    .front_busy      (front_busy),
    .out_valid       (out_valid),
    .expected_profit (expected_profit),
    .exercise        (exercise),
    .cf_out          (cf_out)
  );

`ifdef LS_EXCNT_EN
  // Exercise counter: cleared by a coefficient load, held after the step ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exercise_count <= '0;
    end else if (coef_we) begin
      exercise_count <= '0;
    end else if (out_valid && exercise) begin
      exercise_count <= exercise_count + 1'b1;
    end
  end
`endif

endmodule
